// File: rtl/ifu_fetch_queue.sv
// rtl/ifu_fetch_queue.sv - instruction fetch front end: PC generation, in-order imem requests,
// PC-tagged instruction queue to decode, redirect flush with stale-response dropping.
module ifu_fetch_queue #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_inst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [63:0]   pc_mem_q   [DEPTH];
    logic [63:0]   pc_mem_d   [DEPTH];
    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   inst_mem_d [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW-1:0] fill_q, fill_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] pend_cnt_q, pend_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW:0]   drop_sum;

    logic req_fire;
    logic pop;
    logic resp_fill;
    logic resp_drop;

    // Handshake outputs depend only on registered state and redirect, never on ready.
    assign imem_req_valid = !rst && !redirect_valid && (count_q < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign out_valid      = !rst && !redirect_valid && filled_q[head_q];
    assign out_pc         = pc_mem_q[head_q];
    assign out_inst       = inst_mem_q[head_q];

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign pop       = out_valid && out_ready;
    assign resp_drop = imem_resp_valid && (drop_cnt_q != '0);
    assign resp_fill = imem_resp_valid && (drop_cnt_q == '0) && (pend_cnt_q != '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        filled_d   = filled_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        count_d    = count_q;
        pend_cnt_d = pend_cnt_q;
        drop_cnt_d = drop_cnt_q;
        drop_sum   = {1'b0, drop_cnt_q} + {1'b0, pend_cnt_q};

        if (redirect_valid) begin
            // Every unfilled entry is still owed by memory; a response this cycle pays one off.
            if (imem_resp_valid && (drop_sum != '0)) begin
                drop_sum = drop_sum - 1'b1;
            end
            drop_cnt_d = drop_sum[CW] ? '1 : drop_sum[CW-1:0];
            fetch_pc_d = redirect_pc & ~64'h3;
            filled_d   = '0;
            head_d     = '0;
            tail_d     = '0;
            fill_d     = '0;
            count_d    = '0;
            pend_cnt_d = '0;
        end else begin
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            if (resp_fill) begin
                inst_mem_d[fill_q] = imem_resp_inst;
                filled_d[fill_q]   = 1'b1;
                fill_d             = fill_q + 1'b1;
            end
            if (pop) begin
                filled_d[head_q] = 1'b0;
                head_d           = head_q + 1'b1;
            end
            if (req_fire) begin
                pc_mem_d[tail_q] = fetch_pc_q;
                filled_d[tail_q] = 1'b0;
                tail_d           = tail_q + 1'b1;
                fetch_pc_d       = fetch_pc_q + 64'd4;
            end
            count_d    = count_q + CW'(req_fire) - CW'(pop);
            pend_cnt_d = pend_cnt_q + CW'(req_fire) - CW'(resp_fill);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            filled_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            pend_cnt_q <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            filled_q   <= filled_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_q     <= fill_d;
            count_q    <= count_d;
            pend_cnt_q <= pend_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= pc_mem_d[i];
                inst_mem_q[i] <= inst_mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb/tb_ifu_fetch_queue.sv - self-checking bench for ifu_fetch_queue with queue-based reference model
module tb_ifu_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_inst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;

    ifu_fetch_queue #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_inst(imem_resp_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct { int due; logic [31:0] inst; } resp_t;
    resp_t mem_q[$];
    int    mem_lat  = 1;
    int    last_due = -1;

    typedef struct { logic [63:0] pc; logic [31:0] inst; bit filled; } ent_t;
    ent_t        mq[$];
    logic [63:0] m_pc;
    int          m_drop;

    logic        s_req_valid, s_ov;
    logic [63:0] s_addr, s_opc;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return (lo * 32'h0001_9E37) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mem_q.delete();
        m_pc     = RPC;
        m_drop   = 0;
        last_due = -1;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; out_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_inst = '0;
        #1;
        chk("rst_req_valid_comb", imem_req_valid, 0);
        chk("rst_out_valid_comb", out_valid, 0);
        repeat (n) @(negedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_inst", out_inst, 0);
        model_reset();
    endtask

    // One clock: drive inputs, compare against the model, then advance the model.
    task automatic cycle(input bit rq_rdy, input bit o_rdy, input bit redir, input logic [63:0] rpc);
        bit e_req, e_ov, acc, pop, done;
        int unf, due;
        @(negedge clk);
        rst = 1'b0;
        imem_req_ready = rq_rdy; out_ready = o_rdy;
        redirect_valid = redir;  redirect_pc = rpc;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_inst  = mem_q[0].inst;
            void'(mem_q.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_inst  = $urandom;
        end
        #1;
        s_req_valid = imem_req_valid; s_addr = imem_req_addr;
        s_ov = out_valid; s_opc = out_pc;

        e_req = !redir && (mq.size() < DEPTH);
        e_ov  = !redir && (mq.size() > 0) && mq[0].filled;
        chk("req_valid", imem_req_valid, e_req);
        chk("req_addr", imem_req_addr, m_pc);
        chk("out_valid", out_valid, e_ov);
        if (e_ov) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_inst", out_inst, mq[0].inst);
        end

        acc = e_req && rq_rdy;
        pop = e_ov && o_rdy;
        if (acc) begin
            due = (cyc + mem_lat > last_due + 1) ? cyc + mem_lat : last_due + 1;
            mem_q.push_back('{due, inst_of(m_pc)});
            last_due = due;
        end
        if (redir) begin
            unf = 0;
            foreach (mq[i]) if (!mq[i].filled) unf++;
            m_drop = m_drop + unf - (imem_resp_valid ? 1 : 0);
            if (m_drop < 0) m_drop = 0;
            mq.delete();
            m_pc = {rpc[63:2], 2'b00};
        end else begin
            if (imem_resp_valid) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    done = 0;
                    foreach (mq[i]) begin
                        if (!done && !mq[i].filled) begin
                            mq[i].inst = imem_resp_inst;
                            mq[i].filled = 1;
                            done = 1;
                        end
                    end
                end
            end
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back('{m_pc, 32'h0, 1'b0});
                m_pc = m_pc + 64'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        int acc_cnt, j;
        bit found;
        logic [63:0] rp;

        // Streaming at full rate with 1-cycle memory.
        mem_lat = 1;
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, 0, '0);
            if (i == 0) begin chk("s1_addr0", s_addr, 64'h8000_0000); chk("s1_ov0", s_ov, 0); end
            if (i == 1) begin chk("s1_addr1", s_addr, 64'h8000_0004); chk("s1_ov1", s_ov, 0); end
            if (i == 2) begin chk("s1_ov2", s_ov, 1); chk("s1_pc2", s_opc, 64'h8000_0000); end
            if (i == 3) begin chk("s1_ov3", s_ov, 1); chk("s1_pc3", s_opc, 64'h8000_0004); end
        end

        // Decode stalled: queue fills to DEPTH and requests stop.
        do_reset(1);
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 0, '0);
            if (s_req_valid) acc_cnt++;
        end
        chk("s2_accepted", acc_cnt, 4);
        cycle(1, 1, 0, '0);
        chk("s2_full_req", s_req_valid, 0);
        chk("s2_full_addr", s_addr, 64'h8000_0010);
        chk("s2_pop_pc", s_opc, 64'h8000_0000);
        cycle(1, 1, 0, '0);
        chk("s2_refill_req", s_req_valid, 1);
        chk("s2_pop_pc2", s_opc, 64'h8000_0004);
        repeat (6) cycle(1, 1, 0, '0);

        // Memory not ready: address held.
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, '0);
            chk("s3_hold_addr", s_addr, 64'h8000_0000);
        end
        cycle(1, 1, 0, '0);
        chk("s3_after_addr", s_addr, 64'h8000_0000);
        cycle(1, 1, 0, '0);
        chk("s3_next_addr", s_addr, 64'h8000_0004);
        repeat (4) cycle(1, 1, 0, '0);

        // Redirect with two requests in flight on 3-cycle memory.
        do_reset(1);
        mem_lat = 3;
        cycle(1, 1, 0, '0);
        cycle(1, 1, 0, '0);
        cycle(1, 1, 1, 64'h0000_0000_8000_1002);
        chk("s4_redir_req", s_req_valid, 0);
        found = 0; j = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle(1, 1, 0, '0);
            if (i == 0) chk("s4_new_addr", s_addr, 64'h8000_1000);
            if (s_ov) begin
                found = 1; j = i;
                chk("s4_first_pc", s_opc, 64'h8000_1000);
            end
        end
        chk("s4_seen", found, 1);
        chk("s4_latency", j, 4);
        repeat (6) cycle(1, 1, 0, '0);

        // Redirect coinciding with a response while one more is outstanding.
        do_reset(1);
        mem_lat = 2;
        cycle(1, 1, 0, '0);
        cycle(1, 1, 0, '0);
        cycle(0, 1, 1, 64'h0000_0000_8000_2000);
        chk("s5_redir_ov", s_ov, 0);
        cycle(1, 1, 0, '0);
        chk("s5_stale_ov", s_ov, 0);
        chk("s5_new_addr", s_addr, 64'h8000_2000);
        cycle(1, 1, 0, '0); chk("s5_ov4", s_ov, 0);
        cycle(1, 1, 0, '0); chk("s5_ov5", s_ov, 0);
        cycle(1, 1, 0, '0);
        chk("s5_ov6", s_ov, 1);
        chk("s5_pc6", s_opc, 64'h8000_2000);
        repeat (4) cycle(1, 1, 0, '0);

        // Redirect while the head is being accepted.
        do_reset(1);
        mem_lat = 1;
        repeat (4) cycle(1, 1, 0, '0);
        cycle(1, 1, 1, 64'h0000_0000_8000_3000);
        chk("s6_redir_ov", s_ov, 0);
        cycle(0, 1, 0, '0);
        chk("s6_after_ov", s_ov, 0);
        chk("s6_after_req", s_req_valid, 1);
        chk("s6_after_addr", s_addr, 64'h8000_3000);
        repeat (4) cycle(1, 1, 0, '0);

        // Randomised traffic, including a PC wrap and a mid-run reset.
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            if ((i % 200) == 0) mem_lat = $urandom_range(1, 3);
            if (i == 1500) do_reset(2);
            rp = {$urandom, $urandom};
            if (($urandom % 8) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF4 | 64'($urandom % 4);
            cycle(($urandom % 4) != 0, ($urandom % 10) < 7, ($urandom % 25) == 0, rp);
        end
        repeat (8) cycle(1, 1, 0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
